// File: rtl/buffer_if_id.sv
// rtl/buffer_if_id.sv - IF/ID instruction queue with head-entry field decode
module buffer_if_id #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [31:0]   in_instr,
  input  logic [31:0]   in_pc,
  output logic          in_ready,
  input  logic          flush,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_pc4,
  output logic [5:0]    op,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [4:0]    shamt,
  output logic [5:0]    funct,
  output logic [31:0]   imm_se,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          push;
  logic          pop;

  assign in_ready  = (cnt < FULL);
  assign out_valid = (cnt != '0);
  assign count     = cnt;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is intentionally left unreset; the head is masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

  assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
  assign out_pc4   = out_pc + 32'd4;

  assign op     = out_instr[31:26];
  assign rs     = out_instr[25:21];
  assign rt     = out_instr[20:16];
  assign rd     = out_instr[15:11];
  assign shamt  = out_instr[10:6];
  assign funct  = out_instr[5:0];
  assign imm_se = {{16{out_instr[15]}}, out_instr[15:0]};

endmodule

// File: tb/tb_buffer_if_id.sv
// tb/tb_buffer_if_id.sv - self-checking bench for buffer_if_id
module tb_buffer_if_id;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [31:0] imm_se;
  logic [AW:0] count;

  buffer_if_id #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(in_ready), .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc4(out_pc4), .op(op), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .funct(funct), .imm_se(imm_se), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic        iv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fl;
    logic        ordy;
    int          cnt;
    logic        rdy;
    logic [31:0] hi;
    logic [31:0] hp;
  } vec_t;

  ent_t q[$];
  vec_t vt[13];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int unsigned lo;
    lo = w % 65536;
    return (lo >= 32768) ? (lo + 32'hFFFF0000) : lo;
  endfunction

  task automatic chk_head(input string tag, input logic [31:0] hi, input logic [31:0] hp, input int n);
    chk({tag, " count"}, 32'(count), n);
    chk({tag, " in_ready"}, 32'(in_ready), (n < DEPTH) ? 1 : 0);
    chk({tag, " out_valid"}, 32'(out_valid), (n != 0) ? 1 : 0);
    chk({tag, " out_instr"}, out_instr, hi);
    chk({tag, " out_pc"}, out_pc, hp);
    chk({tag, " out_pc4"}, out_pc4, hp + 4);
    chk({tag, " op"}, 32'(op), hi >> 26);
    chk({tag, " rs"}, 32'(rs), (hi >> 21) % 32);
    chk({tag, " rt"}, 32'(rt), (hi >> 16) % 32);
    chk({tag, " rd"}, 32'(rd), (hi >> 11) % 32);
    chk({tag, " shamt"}, 32'(shamt), (hi >> 6) % 32);
    chk({tag, " funct"}, 32'(funct), hi % 64);
    chk({tag, " imm_se"}, imm_se, ref_imm(hi));
  endtask

  task automatic check_model(input string tag);
    if (q.size() != 0) chk_head(tag, q[0].instr, q[0].pc, q.size());
    else               chk_head(tag, 32'h0, 32'h0, 0);
  endtask

  // Advance one clock, keeping the reference queue in step with the applied inputs.
  task automatic step();
    int sz;
    sz = q.size();
    if (flush) q.delete();
    else begin
      if (sz > 0 && out_ready) void'(q.pop_front());
      if (in_valid && sz < DEPTH) q.push_back({in_instr, in_pc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic ordy);
    in_valid = iv; in_instr = ins; in_pc = pc; flush = fl; out_ready = ordy;
  endtask

  initial begin
    vt[0]  = '{1'b1, 32'h20080005, 32'h00, 1'b0, 1'b0, 1, 1'b1, 32'h20080005, 32'h00};
    vt[1]  = '{1'b1, 32'h8D09FFFC, 32'h04, 1'b0, 1'b1, 1, 1'b1, 32'h8D09FFFC, 32'h04};
    vt[2]  = '{1'b1, 32'hAAAA0001, 32'h08, 1'b0, 1'b0, 2, 1'b1, 32'h8D09FFFC, 32'h04};
    vt[3]  = '{1'b1, 32'hBBBB0002, 32'h0C, 1'b0, 1'b0, 3, 1'b1, 32'h8D09FFFC, 32'h04};
    vt[4]  = '{1'b1, 32'hCCCC0003, 32'h10, 1'b0, 1'b0, 4, 1'b0, 32'h8D09FFFC, 32'h04};
    vt[5]  = '{1'b1, 32'hDDDD0004, 32'h14, 1'b0, 1'b0, 4, 1'b0, 32'h8D09FFFC, 32'h04};
    vt[6]  = '{1'b1, 32'hEEEE0005, 32'h18, 1'b0, 1'b1, 3, 1'b1, 32'hAAAA0001, 32'h08};
    vt[7]  = '{1'b0, 32'h0,        32'h00, 1'b0, 1'b1, 2, 1'b1, 32'hBBBB0002, 32'h0C};
    vt[8]  = '{1'b0, 32'h0,        32'h00, 1'b0, 1'b1, 1, 1'b1, 32'hCCCC0003, 32'h10};
    vt[9]  = '{1'b0, 32'h0,        32'h00, 1'b0, 1'b1, 0, 1'b1, 32'h0,        32'h00};
    vt[10] = '{1'b0, 32'h0,        32'h00, 1'b0, 1'b1, 0, 1'b1, 32'h0,        32'h00};
    vt[11] = '{1'b1, 32'h12345678, 32'h20, 1'b0, 1'b0, 1, 1'b1, 32'h12345678, 32'h20};
    vt[12] = '{1'b1, 32'h00000009, 32'h24, 1'b1, 1'b1, 0, 1'b1, 32'h0,        32'h00};

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #12;
    chk_head("reset", 32'h0, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: first push, field decode, fill to full, drain, flush.
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].iv, vt[i].instr, vt[i].pc, vt[i].fl, vt[i].ordy);
      step();
      chk_head($sformatf("vec%0d", i), vt[i].hi, vt[i].hp, vt[i].cnt);
      chk($sformatf("vec%0d in_ready_tbl", i), 32'(in_ready), 32'(vt[i].rdy));
      if (i == 0) begin
        chk("lit0 op", 32'(op), 32'h08);
        chk("lit0 rt", 32'(rt), 32'd8);
        chk("lit0 imm_se", imm_se, 32'h00000005);
        chk("lit0 out_pc4", out_pc4, 32'h00000004);
      end
      if (i == 1) begin
        chk("lit1 op", 32'(op), 32'h23);
        chk("lit1 rs", 32'(rs), 32'd8);
        chk("lit1 rt", 32'(rt), 32'd9);
        chk("lit1 imm_se", imm_se, 32'hFFFFFFFC);
      end
    end

    // Steady push+pop at count=2 across several pointer wraps.
    drive(1'b1, 32'hA0000000, 32'h100, 1'b0, 1'b0); step();
    drive(1'b1, 32'hA0000001, 32'h104, 1'b0, 1'b0); step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, $urandom, 32'h108 + 32'(i) * 4, 1'b0, 1'b1);
      step();
      chk($sformatf("pp%0d count", i), 32'(count), 32'd2);
      check_model($sformatf("pp%0d", i));
    end

    // Flush with coincident push at count=3.
    drive(1'b1, 32'h0, 32'h0, 1'b1, 1'b0); step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hC0DE0000 + 32'(i), 32'h200 + 32'(i) * 4, 1'b0, 1'b0);
      step();
    end
    chk("preflush count", 32'(count), 32'd3);
    drive(1'b1, 32'hFFFFFFFF, 32'h300, 1'b1, 1'b1);
    step();
    chk_head("flush", 32'h0, 32'h0, 0);

    // Asynchronous reset mid-operation at count=3.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hBEEF0000 + 32'(i), 32'h400 + 32'(i) * 4, 1'b0, 1'b0);
      step();
    end
    chk("prereset count", 32'(count), 32'd3);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk_head("async_rst", 32'h0, 32'h0, 0);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 32'h11111111, 32'h10, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("post_rst out_pc", out_pc, 32'h10);
    check_model("post_rst");

    // Randomized traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 2) != 0));
      step();
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
